// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: default widths,
// waveform mode encodings and FSM state encodings.
package dds_pkg;

  localparam int DDS_PHASE_W = 32;
  localparam int DDS_DATA_W  = 14;

  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_TRI = 2'd1;
  localparam logic [1:0] WAVE_SQR = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/dds_wave_map.sv
// Registered phase-to-sample mapper (pipeline stage 2): saw, triangle or
// square forward sample plus its complement, one cycle of latency.
module dds_wave_map import dds_pkg::*; #(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int DATA_W  = DDS_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic [1:0]         in_mode,
  output logic [DATA_W-1:0]  fwd,
  output logic [DATA_W-1:0]  bwd,
  output logic               vld
);

  logic [DATA_W-1:0] fwd_d, fwd_q, bwd_d, bwd_q, saw_val, tri_val;
  logic              vld_d, vld_q;

  always_comb begin
    saw_val = in_phase[PHASE_W-1 -: DATA_W];
    tri_val = in_phase[PHASE_W-1] ? ~in_phase[PHASE_W-2 -: DATA_W]
                                  :  in_phase[PHASE_W-2 -: DATA_W];
    fwd_d   = fwd_q;
    bwd_d   = bwd_q;
    vld_d   = in_vld;
    if (in_vld) begin
      case (in_mode)
        WAVE_SAW: fwd_d = saw_val;
        WAVE_TRI: fwd_d = tri_val;
        WAVE_SQR: fwd_d = in_phase[PHASE_W-1] ? '1 : '0;
        default:  fwd_d = saw_val;  // reserved encoding behaves as saw
      endcase
      bwd_d = ~fwd_d;
    end
  end

  // bwd is its own flop so that both outputs read 0 out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_q <= '0;
      bwd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      fwd_q <= fwd_d;
      bwd_q <= bwd_d;
      vld_q <= vld_d;
    end
  end

  assign fwd = fwd_q;
  assign bwd = bwd_q;
  assign vld = vld_q;

endmodule

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: burst/continuous sequencing FSM, sample-rate
// divider, period counter and a 2-stage phase -> sample pipeline.
//
// state   | meaning
// ST_IDLE | accumulator held at 0, waiting for a rising edge of reg_wave_en
// ST_RUN  | accumulating phase and issuing a sample on every divider tick
// ST_DONE | burst finished, wave_done high for this single cycle
module dds_wave_gen import dds_pkg::*; #(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int DATA_W  = DDS_DATA_W,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_wave_en,
  input  logic [PHASE_W-1:0] reg_freq_word,
  input  logic [PHASE_W-1:0] reg_phase_offset,
  input  logic [DIV_W-1:0]   reg_sample_div,
  input  logic [CNT_W-1:0]   reg_period_num,
  input  logic [1:0]         reg_wave_mode,
  output logic [DATA_W-1:0]  da_forward_data_out,
  output logic [DATA_W-1:0]  da_backward_data_out,
  output logic               da_data_out_vld,
  output logic               wave_busy,
  output logic               wave_done
);

  logic [1:0]         state_d, state_q, mode_d, mode_q;
  logic               en_q, start, tick, s1_vld_d, s1_vld_q;
  logic [PHASE_W-1:0] freq_d, freq_q, off_d, off_q, acc_d, acc_q;
  logic [PHASE_W-1:0] s1_phase_d, s1_phase_q;
  logic [PHASE_W:0]   acc_sum;
  logic [DIV_W-1:0]   div_l_d, div_l_q, div_cnt_d, div_cnt_q;
  logic [CNT_W-1:0]   per_l_d, per_l_q, per_cnt_d, per_cnt_q, per_inc;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    freq_d     = freq_q;
    off_d      = off_q;
    div_l_d    = div_l_q;
    per_l_d    = per_l_q;
    acc_d      = acc_q;
    div_cnt_d  = div_cnt_q;
    per_cnt_d  = per_cnt_q;
    s1_vld_d   = 1'b0;
    s1_phase_d = s1_phase_q;
    start      = reg_wave_en & ~en_q;
    tick       = (state_q == ST_RUN) && (div_cnt_q == div_l_q);
    acc_sum    = {1'b0, acc_q} + {1'b0, freq_q};
    per_inc    = per_cnt_q + CNT_W'(acc_sum[PHASE_W]);
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (start) begin
          freq_d    = reg_freq_word;
          off_d     = reg_phase_offset;
          div_l_d   = reg_sample_div;
          per_l_d   = reg_period_num;
          mode_d    = reg_wave_mode;
          div_cnt_d = '0;
          per_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          s1_vld_d   = 1'b1;
          s1_phase_d = acc_q + off_q;
          acc_d      = acc_sum[PHASE_W-1:0];
          per_cnt_d  = per_inc;
        end
        // the final wrap takes priority over an abort in the same cycle
        if (tick && acc_sum[PHASE_W] && (per_l_q != '0) && (per_inc == per_l_q))
          state_d = ST_DONE;
        else if (!reg_wave_en)
          state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // en_q resets high so a level already high across reset is not a start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b1;
      mode_q     <= WAVE_SAW;
      freq_q     <= '0;
      off_q      <= '0;
      div_l_q    <= '0;
      per_l_q    <= '0;
      acc_q      <= '0;
      div_cnt_q  <= '0;
      per_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_phase_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= reg_wave_en;
      mode_q     <= mode_d;
      freq_q     <= freq_d;
      off_q      <= off_d;
      div_l_q    <= div_l_d;
      per_l_q    <= per_l_d;
      acc_q      <= acc_d;
      div_cnt_q  <= div_cnt_d;
      per_cnt_q  <= per_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_phase_q <= s1_phase_d;
    end
  end

  dds_wave_map #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) u_map (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (s1_vld_q),
    .in_phase (s1_phase_q),
    .in_mode  (mode_q),
    .fwd      (da_forward_data_out),
    .bwd      (da_backward_data_out),
    .vld      (da_data_out_vld)
  );

  assign wave_busy = (state_q == ST_RUN) | s1_vld_q | da_data_out_vld;
  assign wave_done = (state_q == ST_DONE);

endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
Phase-accumulator DDS that generates the forward/backward 14-bit sample pair and its valid strobe. Its outputs feed the downstream gain/offset adjust stage directly, on the same clock. Register-driven: start/abort, frequency, phase offset, sample-rate divider, waveform mode and burst length in periods. An FSM sequences idle, run and done, and a 2-stage output pipeline produces the samples.

Parameters:
PHASE_W, 32, phase accumulator / tuning word width
DATA_W, 14, output sample width
DIV_W, 16, sample divider width
CNT_W, 16, period counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
reg_wave_en  in  1  level; rising edge starts, low aborts
reg_freq_word  in  PHASE_W  phase increment per sample tick
reg_phase_offset  in  PHASE_W  phase added after accumulator
reg_sample_div  in  DIV_W  tick every (div+1) clk cycles
reg_period_num  in  CNT_W  accumulator wraps per burst; 0 = continuous
reg_wave_mode  in  2  0 saw, 1 triangle, 2 square, 3 treated as saw
da_forward_data_out  out  DATA_W  forward sample
da_backward_data_out  out  DATA_W  backward sample
da_data_out_vld  out  1  one-cycle strobe per sample
wave_busy  out  1  RUN state or pipeline not empty
wave_done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (rst=0, async): FSM=IDLE; accumulator, divider and period counters=0; all outputs 0; pipeline valid bits cleared.
- en_d = reg_wave_en registered. A start event is reg_wave_en & ~en_d.
- IDLE: accumulator=0. On a start event, latch freq_word, phase_offset, sample_div, period_num and wave_mode, clear the counters, go to RUN. Register changes during RUN are ignored.
- RUN: the divider counts 0..div_l. A tick fires when div_cnt==div_l, then div_cnt returns to 0. With div_l=0, a tick fires every cycle, starting on the first RUN cycle.
- On a tick:
  - phase = acc + offset_l (mod 2^32) enters pipeline stage 1.
  - acc <= acc + freq_l.
  - A carry out of the add increments per_cnt.
- If period_num_l != 0 and the wrap makes per_cnt == period_num_l, go to DONE in the next cycle. The sample issued on that tick is the last sample of the burst.
- If reg_wave_en=0 in RUN: go to IDLE next cycle with no wave_done (abort). Any tick in that same cycle still issues its sample.
- If reg_wave_en=0 and the final wrap occur in the same cycle, completion wins: DONE and wave_done.
- DONE: wave_done=1 for exactly one cycle, then IDLE. A new start needs a fresh rising edge of reg_wave_en.
- freq_l=0: the output is constant and no wraps occur. Runs until abort, even when period_num_l != 0.
- Pipeline:
  - Stage 1 registers phase.
  - Stage 2 registers the mapped outputs.
  - da_data_out_vld is asserted exactly 2 cycles after each tick.
  - The pipeline always drains after leaving RUN, including on abort.
- Mapping, with p = stage-1 phase:
  - saw: fwd = p[31:18].
  - triangle: fwd = p[31] ? ~p[30:17] : p[30:17].
  - square: fwd = p[31] ? 14'h3FFF : 0.
  - In all modes, bwd = ~fwd, i.e. 16383 - fwd.
- Output data holds its last value between valid strobes.
- wave_busy = (state==RUN) | any pipeline valid bit set. It is 0 in IDLE once the pipeline is drained.

Decomposition:
- Package dds_pkg holds:
  - the PHASE_W and DATA_W defaults;
  - the wave_mode encodings WAVE_SAW, WAVE_TRI and WAVE_SQR;
  - the FSM state encodings ST_IDLE, ST_RUN and ST_DONE.
- One sub-module, dds_wave_map: a registered mapper, phase in → fwd/bwd out, 1 cycle latency. It forms stage 2 of the pipeline.
- The FSM, accumulator and counters stay in dds_wave_gen.

Test Plan:
- saw, freq=0x4000_0000, offset=0, div=0, period=1, start:
  - 4 vld pulses on consecutive cycles, the first 2 cycles after entering RUN.
  - fwd=0,4096,8192,12288; bwd=16383,12287,8191,4095.
  - wave_done pulses once; wave_busy falls 2 cycles after leaving RUN.
- triangle, same settings: fwd=0,8192,16383,8191.
- square, period=2: fwd=0,0,16383,16383,0,0,16383,16383 over 8 samples, then wave_done.
- saw, offset=0x8000_0000, div=3, period=1: vld every 4th cycle; fwd=8192,12288,0,4096.
- period=0, freq=0x1000_0000:
  - runs past 16 samples with no wave_done.
  - Drop reg_wave_en: at most 2 trailing vld, no wave_done, busy=0 within 3 cycles.
  - Re-raise reg_wave_en: restarts with first fwd=0.
- Assert rst=0 mid-RUN: all outputs 0 immediately (asynchronous); FSM in IDLE. After release, no run until a new rising edge of reg_wave_en.
